// File: rtl/and_chk_pkg.sv
// Shared types for the AND-unit checker: FSM encoding,
// default widths and a saturating counter helper.
package and_chk_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/and_chk_cmp.sv
// Registered compare stage: holds one accepted vector and
// its precomputed match flag for one cycle.
// Ports: clk, rst_n, i_load, i_a/i_b/i_res in;
//        o_valid, o_match, o_a/o_b/o_res out.
module and_chk_cmp
    import and_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_res,
    output logic             o_valid,
    output logic             o_match,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_res
);

    logic             r_valid;
    logic             r_match;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_match <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else begin
            r_valid <= i_load;
            if (i_load) begin
                r_match <= (i_res == (i_a & i_b));
                r_a     <= i_a;
                r_b     <= i_b;
                r_res   <= i_res;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_match = r_match;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_res   = r_res;

endmodule

// File: rtl/and_checker.sv
// Run controller that feeds vectors through the compare
// stage, counts matches/mismatches and keeps the first fail.
// Ports: clk, rst_n, i_start, i_in_valid, i_a/i_b/i_res in;
//        o_in_ready, o_busy, o_done, o_pass, counters, o_ff_* out.
module and_checker
    import and_chk_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int NUM_VEC      = 4,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_res,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [15:0]      o_pass_cnt,
    output logic [15:0]      o_fail_cnt,
    output logic [WIDTH-1:0] o_ff_a,
    output logic [WIDTH-1:0] o_ff_b,
    output logic [WIDTH-1:0] o_ff_res,
    output logic [15:0]      o_ff_idx
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_idx;
    logic [15:0]      r_s1_idx;
    logic [15:0]      r_pass_cnt;
    logic [15:0]      r_fail_cnt;
    logic [WIDTH-1:0] r_ff_a;
    logic [WIDTH-1:0] r_ff_b;
    logic [WIDTH-1:0] r_ff_res;
    logic [15:0]      r_ff_idx;

    logic             w_ready;
    logic             w_start;
    logic             w_accept;
    logic             w_last;
    logic             w_stop;
    logic             w_s1_valid;
    logic             w_s1_match;
    logic [WIDTH-1:0] w_s1_a;
    logic [WIDTH-1:0] w_s1_b;
    logic [WIDTH-1:0] w_s1_res;

    assign w_ready = (r_state == ST_RUN);
    assign w_start = i_start &&
                     (r_state == ST_IDLE ||
                      r_state == ST_DONE ||
                      r_state == ST_FAIL);
    // A retiring mismatch in stop mode blocks the vector
    // offered on the same edge so it never enters stage 1.
    assign w_stop   = STOP_ON_FAIL && w_s1_valid && !w_s1_match;
    assign w_accept = i_in_valid && w_ready && !w_stop;
    assign w_last   = (r_idx == 16'(NUM_VEC - 1));

    and_chk_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_res   (i_res),
        .o_valid (w_s1_valid),
        .o_match (w_s1_match),
        .o_a     (w_s1_a),
        .o_b     (w_s1_b),
        .o_res   (w_s1_res)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (w_start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_stop)
                    w_state_nxt = ST_FAIL;
                else if (w_accept && w_last)
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_stop)
                    w_state_nxt = ST_FAIL;
                else if (w_s1_valid)
                    w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_s1_idx   <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_res   <= '0;
            r_ff_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_idx      <= '0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_ff_a     <= '0;
                r_ff_b     <= '0;
                r_ff_res   <= '0;
                r_ff_idx   <= '0;
            end else begin
                if (w_accept) begin
                    r_idx    <= r_idx + 16'd1;
                    r_s1_idx <= r_idx;
                end
                if (w_s1_valid) begin
                    if (w_s1_match) begin
                        r_pass_cnt <= sat_inc(r_pass_cnt);
                    end else begin
                        r_fail_cnt <= sat_inc(r_fail_cnt);
                        // Zero fail count marks the first mismatch.
                        if (r_fail_cnt == '0) begin
                            r_ff_a   <= w_s1_a;
                            r_ff_b   <= w_s1_b;
                            r_ff_res <= w_s1_res;
                            r_ff_idx <= r_s1_idx;
                        end
                    end
                end
            end
        end
    end

    assign o_in_ready = w_ready;
    assign o_busy     = (r_state == ST_RUN) ||
                        (r_state == ST_DRAIN);
    assign o_done     = (r_state == ST_DONE) ||
                        (r_state == ST_FAIL);
    assign o_pass     = o_done && (r_fail_cnt == '0);
    assign o_pass_cnt = r_pass_cnt;
    assign o_fail_cnt = r_fail_cnt;
    assign o_ff_a     = r_ff_a;
    assign o_ff_b     = r_ff_b;
    assign o_ff_res   = r_ff_res;
    assign o_ff_idx   = r_ff_idx;

endmodule

// File: tb/tb_and_checker.sv
// Directed bench for and_checker: two instances, one per
// STOP_ON_FAIL setting, driven by the same stimulus.
module tb_and_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic        i_in_valid;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic [15:0] i_res;

    logic        rdy0, busy0, done0, pass0;
    logic [15:0] pc0, fc0, ffa0, ffb0, ffr0, ffi0;
    logic        rdy1, busy1, done1, pass1;
    logic [15:0] pc1, fc1, ffa1, ffb1, ffr1, ffi1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    and_checker #(
        .WIDTH(16), .NUM_VEC(4), .STOP_ON_FAIL(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_in_valid(i_in_valid), .o_in_ready(rdy0),
        .i_a(i_a), .i_b(i_b), .i_res(i_res),
        .o_busy(busy0), .o_done(done0), .o_pass(pass0),
        .o_pass_cnt(pc0), .o_fail_cnt(fc0),
        .o_ff_a(ffa0), .o_ff_b(ffb0), .o_ff_res(ffr0),
        .o_ff_idx(ffi0)
    );

    and_checker #(
        .WIDTH(16), .NUM_VEC(4), .STOP_ON_FAIL(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_in_valid(i_in_valid), .o_in_ready(rdy1),
        .i_a(i_a), .i_b(i_b), .i_res(i_res),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_pass_cnt(pc1), .o_fail_cnt(fc1),
        .o_ff_a(ffa1), .o_ff_b(ffb1), .o_ff_res(ffr1),
        .o_ff_idx(ffi1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ok;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " rdy0"}, 32'(rdy0), 0);
        chk({tag, " busy0"}, 32'(busy0), 0);
        chk({tag, " done0"}, 32'(done0), 0);
        chk({tag, " pass0"}, 32'(pass0), 0);
        chk({tag, " pc0"}, 32'(pc0), 0);
        chk({tag, " fc0"}, 32'(fc0), 0);
        chk({tag, " ffi0"}, 32'(ffi0), 0);
        chk({tag, " ffa0"}, 32'(ffa0), 0);
        chk({tag, " done1"}, 32'(done1), 0);
        chk({tag, " busy1"}, 32'(busy1), 0);
        chk({tag, " pc1"}, 32'(pc1), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start    = 1'b1;
        i_in_valid = 1'b1;
        i_a        = 16'h0001;
        i_b        = 16'h0001;
        i_res      = 16'h0000;
        @(negedge clk);
        i_start    = 1'b0;
        i_in_valid = 1'b0;
    endtask

    // Runs NUM_VEC table entries from base; dut1 is checked as
    // well when its stop behaviour cannot differ from dut0.
    task automatic run_std(input int base, input bit toggle,
                           input bit chk1, input string tag);
        int ep = 0;
        int ef = 0;
        int fi = -1;
        pulse_start();
        chk({tag, " busy after start"}, 32'(busy0), 1);
        chk({tag, " pc clear"}, 32'(pc0), 0);
        for (int i = 0; i < 4; i++) begin
            if (toggle) begin
                i_in_valid = 1'b0;
                i_start    = 1'b1;
                @(negedge clk);
                i_start    = 1'b0;
            end
            i_a        = tv[base + i].a;
            i_b        = tv[base + i].b;
            i_res      = tv[base + i].res;
            i_in_valid = 1'b1;
            chk({tag, " in_ready"}, 32'(rdy0), 1);
            @(negedge clk);
            i_in_valid = 1'b0;
            chk({tag, " pc run"}, 32'(pc0), 32'(ep));
            chk({tag, " fc run"}, 32'(fc0), 32'(ef));
            if (chk1) chk({tag, " pc1 run"}, 32'(pc1), 32'(ep));
            if (tv[base + i].ok) ep++;
            else begin
                if (fi < 0) fi = base + i;
                ef++;
            end
        end
        chk({tag, " drain busy"}, 32'(busy0), 1);
        chk({tag, " drain done"}, 32'(done0), 0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk({tag, " done"}, 32'(done0), 1);
            chk({tag, " busy"}, 32'(busy0), 0);
            chk({tag, " pass"}, 32'(pass0), 32'(ef == 0));
            chk({tag, " pc"}, 32'(pc0), 32'(ep));
            chk({tag, " fc"}, 32'(fc0), 32'(ef));
            if (chk1) begin
                chk({tag, " done1"}, 32'(done1), 1);
                chk({tag, " fc1"}, 32'(fc1), 32'(ef));
                chk({tag, " pass1"}, 32'(pass1), 32'(ef == 0));
            end
            if (fi >= 0) begin
                chk({tag, " ff_idx"}, 32'(ffi0), 32'(fi - base));
                chk({tag, " ff_a"}, 32'(ffa0), 32'(tv[fi].a));
                chk({tag, " ff_b"}, 32'(ffb0), 32'(tv[fi].b));
                chk({tag, " ff_res"}, 32'(ffr0), 32'(tv[fi].res));
                if (chk1) chk({tag, " ff_idx1"}, 32'(ffi1),
                              32'(fi - base));
            end else begin
                chk({tag, " ff_idx clr"}, 32'(ffi0), 0);
                chk({tag, " ff_res clr"}, 32'(ffr0), 0);
            end
            i_in_valid = 1'b1;
            @(negedge clk);
            i_in_valid = 1'b0;
        end
    endtask

    initial begin
        tv[0]  = '{16'h0000, 16'h0000, 16'h0000, 1'b1};
        tv[1]  = '{16'h0001, 16'h0000, 16'h0000, 1'b1};
        tv[2]  = '{16'h0000, 16'h0001, 16'h0000, 1'b1};
        tv[3]  = '{16'h0001, 16'h0001, 16'h0001, 1'b1};
        tv[4]  = '{16'h0000, 16'h0000, 16'h0000, 1'b1};
        tv[5]  = '{16'h0001, 16'h0000, 16'h0000, 1'b1};
        tv[6]  = '{16'h0000, 16'h0001, 16'h0000, 1'b1};
        tv[7]  = '{16'h0001, 16'h0001, 16'h0000, 1'b0};
        tv[8]  = '{16'h0000, 16'h0000, 16'h0000, 1'b1};
        tv[9]  = '{16'h0001, 16'h0000, 16'hFFFF, 1'b0};
        tv[10] = '{16'h0000, 16'h0001, 16'h0000, 1'b1};
        tv[11] = '{16'h0001, 16'h0001, 16'h0001, 1'b1};
        tv[12] = '{16'hF0F0, 16'hFF00, 16'hF000, 1'b1};
        tv[13] = '{16'hAAAA, 16'h5555, 16'h0000, 1'b1};
        tv[14] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};
        tv[15] = '{16'h1234, 16'h00FF, 16'h0034, 1'b1};

        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_in_valid = 1'b0;
        i_a        = '0;
        i_b        = '0;
        i_res      = '0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        i_in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        i_in_valid = 1'b0;
        chk("idle valid ignored pc", 32'(pc0), 0);
        chk("idle no ready", 32'(rdy0), 0);

        run_std(0, 1'b0, 1'b1, "allpass");
        run_std(4, 1'b0, 1'b1, "lastfail");

        // Stop-on-fail with in_valid held high.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            i_a        = tv[8 + i].a;
            i_b        = tv[8 + i].b;
            i_res      = tv[8 + i].res;
            i_in_valid = 1'b1;
            @(negedge clk);
            if (i == 2) begin
                chk("sof done1", 32'(done1), 1);
                chk("sof ready1", 32'(rdy1), 0);
                chk("sof pass1", 32'(pass1), 0);
                chk("sof pc1", 32'(pc1), 1);
                chk("sof fc1", 32'(fc1), 1);
                chk("sof ffi1", 32'(ffi1), 1);
                chk("sof ffr1", 32'(ffr1), 32'h0000FFFF);
                chk("sof ready0", 32'(rdy0), 1);
            end
        end
        repeat (3) @(negedge clk);
        i_in_valid = 1'b0;
        chk("sof hold pc1", 32'(pc1), 1);
        chk("sof hold fc1", 32'(fc1), 1);
        chk("sof hold done1", 32'(done1), 1);
        chk("nostop done0", 32'(done0), 1);
        chk("nostop pc0", 32'(pc0), 3);
        chk("nostop fc0", 32'(fc0), 1);
        chk("nostop ffi0", 32'(ffi0), 1);
        chk("nostop ffb0", 32'(ffb0), 0);

        run_std(12, 1'b1, 1'b1, "toggle");

        // Reset in the middle of a run.
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            i_a        = tv[i].a;
            i_b        = tv[i].b;
            i_res      = tv[i].res;
            i_in_valid = 1'b1;
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        chk("pre-reset pc", 32'(pc0), 1);
        chk("pre-reset busy", 32'(busy0), 1);
        #2 rst_n = 1'b0;
        #1 chk_idle_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_std(0, 1'b0, 1'b1, "restart");

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/and_checker.md
AND_CHECKER -- requirements
Module: and_checker

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width.
REQ-002 Parameter NUM_VEC, default 4, vectors per run; range 1..65535.
REQ-003 Parameter STOP_ON_FAIL, default 0; 1 halts the run at the first mismatch.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a run.
REQ-007 in_valid  in  1  vector (a, b, res) present.
REQ-008 in_ready  out  1  checker accepts a vector this cycle.
REQ-009 a, b  in  WIDTH  operands driven to the AND unit.
REQ-010 res  in  WIDTH  AND-unit result under check.
REQ-011 busy  out  1  run in progress.
REQ-012 done  out  1  run finished; held until next start.
REQ-013 pass  out  1  valid with done; 1 when fail_cnt == 0.
REQ-014 pass_cnt, fail_cnt  out  16  matching and mismatching vector counts.
REQ-015 ff_a, ff_b, ff_res  out  WIDTH  first failing vector.
REQ-016 ff_idx  out  16  index (0-based) of the first failing vector.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN, DONE, FAIL.
REQ-018 The FSM SHALL transition IDLE/DONE/FAIL -> RUN on start, clearing counters, ff_* registers, and the accept index.
REQ-019 in_ready SHALL be 1 only in RUN; a vector is accepted on an edge where in_valid & in_ready.
REQ-020 An accepted vector SHALL be registered in stage 1; the compare res == (a & b) SHALL update the counters on the following edge (latency 1).
REQ-021 RUN SHALL go to DRAIN on the edge that accepts vector NUM_VEC-1.
REQ-022 DRAIN SHALL go to DONE once the stage-1 compare retires.
REQ-023 With STOP_ON_FAIL=1, the first mismatch retiring SHALL move the FSM to FAIL, drop in_ready the same edge, and discard any vector already accepted behind it.
REQ-024 ff_* SHALL be captured only on the first mismatch of a run and held thereafter.
REQ-025 Counters SHALL saturate at 16'hFFFF.
REQ-026 busy SHALL be 1 in RUN and DRAIN.
REQ-027 done SHALL be 1 in DONE and FAIL.
REQ-028 start SHALL be ignored during RUN and DRAIN.
REQ-029 in_valid outside RUN SHALL be ignored with no counter change.
REQ-030 start and in_valid in the same cycle in IDLE SHALL start the run without accepting that vector.

Reset
REQ-031 rst_n low SHALL force IDLE immediately, with all counters, ff_*, the index, and the stage-1 valid at 0; in_ready, busy, done, and pass SHALL be 0.
REQ-032 Reset mid-run SHALL abandon the run with no partial done.

Structure
REQ-033 The FSM state encoding and WIDTH default SHALL live in shared package and_chk_pkg.
REQ-034 One sub-module, and_chk_cmp (registered compare stage: valid, match, captured vector), SHALL be instantiated once.

Verification
REQ-035 Reset, start, then vectors (0,0,0), (1,0,0), (0,1,0), (1,1,1) -> done, pass=1, pass_cnt=4, fail_cnt=0.
REQ-036 Same vectors, but 4th res=0, STOP_ON_FAIL=0 -> done, pass=0, fail_cnt=1, ff_idx=3, ff_a=1, ff_b=1, ff_res=0.
REQ-037 STOP_ON_FAIL=1, 2nd vector res=16'hFFFF, in_valid held high -> FAIL 1 cycle after retirement, pass_cnt=1, fail_cnt=1, in_ready=0.
REQ-038 rst_n low after 2 accepted vectors -> all outputs 0 asynchronously; a new start then restarts at index 0.
REQ-039 in_valid toggling every other cycle -> accepted count = NUM_VEC exactly, done 1 cycle after the last acceptance retires.
